// File: rtl/freq_det_pkg.sv
// Shared types and defaults for the frequency/ratio detector.
// Holds the measurement FSM state encoding and the default counter width,
// plus a small helper that sizes the lock-match counter.
package freq_det_pkg;

    // Default width of the period / high-time counters and outputs
    localparam int DEF_CNT_W = 16;

    // Measurement FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        TIMEOUT   = 2'd2
    } state_t;

    // Bits needed to count consecutive equal periods up to lock_cnt
    function automatic int match_width(input int lock_cnt);
        return (lock_cnt < 2) ? 1 : $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Input conditioning and rising-edge detection for the frequency detector.
// With FREQ_DET_SYNC_EN defined, sig_in passes a 2-FF synchronizer (reset 0)
// and may be asynchronous to clk. Without it, sig_in must be synchronous to clk
// and is used directly as s_q, so a rise is reported two cycles earlier.
// In both builds s_prev is the one-cycle history used for the edge detect.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic s_q,
    output logic rise
);

    logic s_prev;

`ifdef FREQ_DET_SYNC_EN
    logic sync_meta;
    logic sync_out;

    // Two-stage synchronizer followed by the edge-history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            s_prev    <= 1'b0;
        end else begin
            sync_meta <= sig_in;
            sync_out  <= sync_meta;
            s_prev    <= sync_out;
        end
    end

    assign s_q = sync_out;
`else
    // sig_in is already clk-synchronous, so only the edge-history register is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= sig_in;
        end
    end

    assign s_q = sig_in;
`endif

    assign rise = s_q & ~s_prev;

endmodule

// File: rtl/freq_ratio_detector.sv
// Frequency / ratio detector: measures a slow periodic input against clk.
// Reports the rise-to-rise period and the high time in clk cycles, an odd-period
// flag, a lock flag (LOCK_CNT consecutive equal periods) and a timeout flag
// (no rising edge for MAX_PERIOD cycles).
// Build option: FREQ_DET_SYNC_EN adds a 2-FF input synchronizer inside
// sync_edge_detect; measured values are identical in both builds.
module freq_ratio_detector
    import freq_det_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_PERIOD = 2**CNT_W - 1,
    parameter int LOCK_CNT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             is_odd,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MATCH_W = match_width(LOCK_CNT);

    localparam logic [CNT_W-1:0]   MAX_P       = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_SAT   = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W:0]   LOCK_THRESH = (MATCH_W + 1)'(LOCK_CNT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   hi_cnt;
    logic [MATCH_W-1:0] match;
    logic               have_prev;

    logic               s_q;
    logic               rise;
    logic [MATCH_W:0]   match_inc;
    logic               period_equal;

    sync_edge_detect u_sync_edge_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .s_q    (s_q),
        .rise   (rise)
    );

    assign match_inc    = {1'b0, match} + {{MATCH_W{1'b0}}, 1'b1};
    assign period_equal = have_prev && (cnt == period);

    // Measurement FSM with counters, registered results and lock tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_EDGE;
            cnt        <= '0;
            hi_cnt     <= '0;
            match      <= '0;
            have_prev  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            is_odd     <= 1'b0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                WAIT_EDGE: begin
                    cnt    <= '0;
                    hi_cnt <= '0;
                    if (rise) begin
                        state  <= MEASURE;
                        cnt    <= CNT_ONE;
                        hi_cnt <= CNT_ONE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hi_cnt;
                        is_odd     <= cnt[0];
                        meas_valid <= 1'b1;
                        have_prev  <= 1'b1;
                        cnt        <= CNT_ONE;
                        hi_cnt     <= CNT_ONE;
                        if (period_equal) begin
                            match <= (match == MATCH_SAT) ? match : match_inc[MATCH_W-1:0];
                            if (match_inc >= LOCK_THRESH) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match  <= '0;
                            locked <= 1'b0;
                        end
                    end else if (cnt == MAX_P) begin
                        state     <= TIMEOUT;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match     <= '0;
                        have_prev <= 1'b0;
                        cnt       <= '0;
                        hi_cnt    <= '0;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        hi_cnt <= hi_cnt + {{(CNT_W-1){1'b0}}, s_q};
                    end
                end

                TIMEOUT: begin
                    cnt    <= '0;
                    hi_cnt <= '0;
                    if (rise) begin
                        state   <= MEASURE;
                        timeout <= 1'b0;
                        cnt     <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                    end
                end

                default: begin
                    state  <= WAIT_EDGE;
                    cnt    <= '0;
                    hi_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_ratio_detector.sv
// Testbench for freq_ratio_detector (CNT_W=8, MAX_PERIOD=255, LOCK_CNT=2).
// Works in both builds; FREQ_DET_SYNC_EN selects the expected detection latency.
// A waveform model pushes the expected measurement for every closed period when the
// closing rise is driven; the sampler queues every meas_valid the DUT produces.
module tb_freq_ratio_detector;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 2;
`ifdef FREQ_DET_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  per;
        logic [7:0]  hi;
        logic        odd;
        logic        lk;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             is_odd;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t e;
    rec_t o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit armed;
    bit have_prev;
    int run;
    int last_len;
    int last_high;
    int prev_p;
    int last_rise_cyc;

    logic tout_prev;
    int   tout_rise_cyc;
    int   tout_fall_cyc;
    logic tout_lk;

    freq_ratio_detector #(
        .CNT_W      (CNT_W),
        .MAX_PERIOD (255),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .is_odd     (is_odd),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // One clock: sample outputs 1 ns after the edge, then drive the next input bit
    task step(input logic b);
        rec_t r;
        @(posedge clk);
        cyc++;
        #1;
        if (meas_valid === 1'b1) begin
            r.cyc = cyc;
            r.per = period;
            r.hi  = high_time;
            r.odd = is_odd;
            r.lk  = locked;
            obs_q.push_back(r);
        end
        if (timeout === 1'b1 && tout_prev !== 1'b1) begin
            tout_rise_cyc = cyc;
            tout_lk       = locked;
        end
        if (timeout === 1'b0 && tout_prev === 1'b1) tout_fall_cyc = cyc;
        tout_prev = timeout;
        sig_in = b;
    endtask

    // One input period: h cycles high then l low; the opening rise closes the previous one
    task seg(input int h, input int l);
        rec_t r;
        int   p;
        for (int i = 0; i < h + l; i++) begin
            step(i < h);
            if (i == 0) begin
                last_rise_cyc = cyc;
                if (armed) begin
                    p = last_len;
                    if (have_prev && p == prev_p) run++;
                    else run = 1;
                    r.cyc = cyc + LAT;
                    r.per = 8'(p);
                    r.hi  = 8'(last_high);
                    r.odd = p[0];
                    r.lk  = (run >= LOCK_CNT);
                    prev_p    = p;
                    have_prev = 1'b1;
                    exp_q.push_back(r);
                end
                armed     = 1'b1;
                last_len  = h + l;
                last_high = h;
            end
        end
    endtask

    task clear_model();
        armed     = 1'b0;
        have_prev = 1'b0;
        run       = 0;
        exp_q.delete();
        obs_q.delete();
        tout_prev     = 1'b0;
        tout_rise_cyc = -1;
        tout_fall_cyc = -1;
    endtask

    task do_reset();
        #2;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task test_reset();
        #1;
        rst_n = 1'b0;
        #11;
        checks++;
        if ({period, high_time, is_odd, meas_valid, locked, timeout} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got period=%0d high=%0d odd=%b valid=%b locked=%b timeout=%b, expected all 0",
                     period, high_time, is_odd, meas_valid, locked, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task test_div5();
        $display("[TB] divide-by-5, high 3 / low 2");
        do_reset();
        repeat (4) seg(3, 2);
        seg(1, LAT + 3);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL div5_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL div5_valid: got cyc=%0d per=%0d hi=%0d odd=%b lk=%b, expected cyc=%0d per=%0d hi=%0d odd=%b lk=%b",
                         o.cyc, o.per, o.hi, o.odd, o.lk, e.cyc, e.per, e.hi, e.odd, e.lk);
            end
        end
        checks++;
        if (period !== 8'd5 || high_time !== 8'd3) begin
            errors++;
            $display("[TB] FAIL div5_hold: got period=%0d high=%0d, expected 5 and 3", period, high_time);
        end
    endtask

    task test_div4();
        $display("[TB] divide-by-4, high 2 / low 2");
        do_reset();
        repeat (3) seg(2, 2);
        seg(1, LAT + 3);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL div4_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL div4_valid: got cyc=%0d per=%0d hi=%0d odd=%b lk=%b, expected cyc=%0d per=%0d hi=%0d odd=%b lk=%b",
                         o.cyc, o.per, o.hi, o.odd, o.lk, e.cyc, e.per, e.hi, e.odd, e.lk);
            end
        end
    endtask

    task test_switch();
        $display("[TB] switch from divide-by-5 to high 4 / low 3 while locked");
        do_reset();
        repeat (4) seg(3, 2);
        repeat (2) seg(4, 3);
        seg(1, LAT + 3);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL switch_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL switch_valid: got cyc=%0d per=%0d hi=%0d odd=%b lk=%b, expected cyc=%0d per=%0d hi=%0d odd=%b lk=%b",
                         o.cyc, o.per, o.hi, o.odd, o.lk, e.cyc, e.per, e.hi, e.odd, e.lk);
            end
        end
    endtask

    task test_timeout();
        int k;
        int r;
        $display("[TB] timeout after a rise held low, then resume");
        do_reset();
        repeat (3) seg(3, 2);
        seg(1, 0);
        k = last_rise_cyc;
        for (int i = 0; i < 300; i++) step(1'b0);
        checks++;
        if (tout_rise_cyc !== k + LAT + 255) begin
            errors++;
            $display("[TB] FAIL timeout_cycle: got timeout at cycle %0d, expected %0d", tout_rise_cyc, k + LAT + 255);
        end
        checks++;
        if (tout_lk !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_flags: got locked=%b timeout=%b, expected locked=0 timeout=1", tout_lk, timeout);
        end
        armed     = 1'b0;
        have_prev = 1'b0;
        run       = 0;
        seg(2, 2);
        r = last_rise_cyc;
        seg(2, 2);
        seg(1, LAT + 3);
        checks++;
        if (tout_fall_cyc !== r + LAT) begin
            errors++;
            $display("[TB] FAIL timeout_clear: got timeout low at cycle %0d, expected %0d", tout_fall_cyc, r + LAT);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL timeout_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL timeout_valid: got cyc=%0d per=%0d hi=%0d odd=%b lk=%b, expected cyc=%0d per=%0d hi=%0d odd=%b lk=%b",
                         o.cyc, o.per, o.hi, o.odd, o.lk, e.cyc, e.per, e.hi, e.odd, e.lk);
            end
        end
    endtask

    task test_midreset();
        $display("[TB] asynchronous reset in the middle of a measurement");
        do_reset();
        repeat (3) seg(3, 2);
        step(1'b1);
        step(1'b1);
        checks++;
        if (period !== 8'd5 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_before: got period=%0d locked=%b, expected 5 and 1", period, locked);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL midreset_pre_valid: got cyc=%0d per=%0d hi=%0d odd=%b lk=%b, expected cyc=%0d per=%0d hi=%0d odd=%b lk=%b",
                         o.cyc, o.per, o.hi, o.odd, o.lk, e.cyc, e.per, e.hi, e.odd, e.lk);
            end
        end
        #2;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        #1;
        checks++;
        if ({period, high_time, is_odd, meas_valid, locked, timeout} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got period=%0d high=%0d odd=%b valid=%b locked=%b timeout=%b, expected all 0",
                     period, high_time, is_odd, meas_valid, locked, timeout);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        repeat (3) seg(3, 2);
        seg(1, LAT + 3);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL midreset_valid: got cyc=%0d per=%0d hi=%0d odd=%b lk=%b, expected cyc=%0d per=%0d hi=%0d odd=%b lk=%b",
                         o.cyc, o.per, o.hi, o.odd, o.lk, e.cyc, e.per, e.hi, e.odd, e.lk);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] detection latency %0d cycles", LAT);
        test_reset();
        test_div5();
        test_div4();
        test_switch();
        test_timeout();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
